// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the multiply-accumulate stage.
package mac_pkg;

    localparam int unsigned MUL_W  = 8;
    localparam int unsigned PROD_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StAccum = ST_ACCUM,
        StDone  = ST_DONE
    } state_e;

endpackage

// File: rtl/mac_accum8_if.sv
// Control, operand stream and result stream of mac_accum8.
interface mac_accum8_if
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [MUL_W-1:0] in_a;
    logic [MUL_W-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;
    logic             busy;

    modport slave (
        input  start, len, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, busy
    );

    modport master (
        output start, len, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, busy
    );

endinterface

// File: rtl/multiplier8.sv
// Combinational 8x8 unsigned multiplier.
module multiplier8
    import mac_pkg::*;
(
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic [PROD_W-1:0] p
);

    assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mac_accum8.sv
// Multiply-accumulate stage: registers each 8x8 product and sums a run of
// len products into a saturating accumulator, then offers the result.
module mac_accum8
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned LEN_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    mac_accum8_if.slave bus
);

    localparam logic [LEN_W-1:0] CntOne = LEN_W'(1);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [LEN_W-1:0]  sum_cnt_q, sum_cnt_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic              prod_v_q, prod_v_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;

    logic [PROD_W-1:0] mul_p;
    logic [ACC_W:0]    sum_ext;
    logic              in_ready;
    logic              out_valid;
    logic              accept;

    multiplier8 u_mul (
        .a (bus.in_a),
        .b (bus.in_b),
        .p (mul_p)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        acc_cnt_d = acc_cnt_q;
        sum_cnt_d = sum_cnt_q;
        prod_d    = prod_q;
        prod_v_d  = prod_v_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        // One spare bit catches the carry that triggers saturation.
        sum_ext   = {1'b0, acc_q} + (ACC_W + 1)'(prod_q);

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    len_d     = bus.len;
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                    acc_cnt_d = '0;
                    sum_cnt_d = '0;
                    prod_v_d  = 1'b0;
                    state_d   = (bus.len == '0) ? StDone : StAccum;
                end
            end
            StAccum: begin
                in_ready = (acc_cnt_q != len_q);
                accept   = bus.in_valid && in_ready;
                prod_v_d = accept;
                if (accept) begin
                    prod_d    = mul_p;
                    acc_cnt_d = acc_cnt_q + CntOne;
                end
                if (prod_v_q) begin
                    if (sum_ext[ACC_W]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum_ext[ACC_W-1:0];
                    end
                    sum_cnt_d = sum_cnt_q + CntOne;
                    if (sum_cnt_d == len_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            len_q     <= '0;
            acc_cnt_q <= '0;
            sum_cnt_q <= '0;
            prod_q    <= '0;
            prod_v_q  <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            acc_cnt_q <= acc_cnt_d;
            sum_cnt_q <= sum_cnt_d;
            prod_q    <= prod_d;
            prod_v_q  <= prod_v_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mac_accum8.sv
// Self-checking bench for mac_accum8: vector table through a result scoreboard,
// plus hand sequences for reset mid-run and saturation on a 16-bit build.
module tb_mac_accum8;
    import mac_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_accum8_if #(.ACC_W(24), .LEN_W(8)) m_if ();
    mac_accum8_if #(.ACC_W(16), .LEN_W(8)) s_if ();

    mac_accum8 #(.ACC_W(24), .LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if.slave)
    );

    mac_accum8 #(.ACC_W(16), .LEN_W(8)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if.slave)
    );

    typedef struct packed {
        logic [7:0]      len;
        logic [7:0]      gap;
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        logic [23:0]     sum;
        logic            ovf;
        logic [7:0]      hold;
    } vec_t;

    typedef struct packed {
        logic [23:0] sum;
        logic        ovf;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input int len, input int gap, input int a0, input int b0,
                                input int a1, input int b1, input int a2, input int b2,
                                input int a3, input int b3, input int sum, input int hold);
        vec_t v;
        v.len  = 8'(len);
        v.gap  = 8'(gap);
        v.a[0] = 8'(a0); v.b[0] = 8'(b0);
        v.a[1] = 8'(a1); v.b[1] = 8'(b1);
        v.a[2] = 8'(a2); v.b[2] = 8'(b2);
        v.a[3] = 8'(a3); v.b[3] = 8'(b3);
        v.sum  = 24'(sum);
        v.ovf  = 1'b0;
        v.hold = 8'(hold);
        return v;
    endfunction

    // Inputs change on negedges; the DUT samples them on the following posedge.
    task automatic run_main(input vec_t v);
        exp_t e;
        exp_t got;
        int   n;
        e.sum = v.sum;
        e.ovf = v.ovf;
        exp_q.push_back(e);
        m_if.start = 1'b1;
        m_if.len   = v.len;
        @(negedge clk);
        m_if.start = 1'b0;
        if (v.len == 0) check("zero_len_in_ready", 32'(m_if.in_ready), 0);
        for (int i = 0; i < int'(v.len); i++) begin
            m_if.in_valid = 1'b1;
            m_if.in_a     = v.a[i];
            m_if.in_b     = v.b[i];
            n = 0;
            while (!m_if.in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) check("in_ready_timeout", 0, 1);
            @(negedge clk);
            m_if.in_valid = 1'b0;
            if (i != int'(v.len) - 1) begin
                repeat (int'(v.gap)) begin
                    @(negedge clk);
                    check("gap_no_out_valid", 32'(m_if.out_valid), 0);
                end
            end
        end
        if (v.len != 0) begin
            check("latency_early", 32'(m_if.out_valid), 0);
            @(negedge clk);
            check("latency_two", 32'(m_if.out_valid), 1);
        end else begin
            check("zero_len_valid", 32'(m_if.out_valid), 1);
        end
        n = 0;
        while (!m_if.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!m_if.out_valid) begin
            check("out_valid_timeout", 0, 1);
            void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            got = exp_q.pop_front();
            check("out_sum", 32'(m_if.out_sum), 32'(got.sum));
            check("out_ovf", 32'(m_if.out_ovf), 32'(got.ovf));
        end
        // Result held under backpressure; starts and operand pairs are ignored.
        for (int h = 0; h < int'(v.hold); h++) begin
            m_if.start    = 1'b1;
            m_if.len      = 8'd1;
            m_if.in_valid = 1'b1;
            check("done_in_ready", 32'(m_if.in_ready), 0);
            @(negedge clk);
            m_if.start = 1'b0;
            check("hold_valid", 32'(m_if.out_valid), 1);
            check("hold_sum", 32'(m_if.out_sum), 32'(v.sum));
        end
        m_if.in_valid  = 1'b0;
        m_if.out_ready = 1'b1;
        @(negedge clk);
        m_if.out_ready = 1'b0;
        check("post_hs_valid", 32'(m_if.out_valid), 0);
        check("post_hs_busy", 32'(m_if.busy), 0);
    endtask

    initial begin
        int n;
        m_if.start = 1'b0; m_if.len = '0; m_if.in_valid = 1'b0;
        m_if.in_a = '0; m_if.in_b = '0; m_if.out_ready = 1'b0;
        s_if.start = 1'b0; s_if.len = '0; s_if.in_valid = 1'b0;
        s_if.in_a = '0; s_if.in_b = '0; s_if.out_ready = 1'b0;

        vecs[0] = mk(3, 0, 3, 4, 5, 6, 255, 255, 0, 0, 65067, 0);
        vecs[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2] = mk(4, 2, 1, 1, 2, 2, 3, 3, 4, 4, 30, 5);
        vecs[3] = mk(2, 1, 100, 200, 17, 3, 0, 0, 0, 0, 20051, 0);
        vecs[4] = mk(4, 0, 255, 255, 255, 255, 255, 255, 255, 255, 260100, 2);

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(m_if.in_ready), 0);
        check("rst_out_valid", 32'(m_if.out_valid), 0);
        check("rst_out_sum", 32'(m_if.out_sum), 0);
        check("rst_out_ovf", 32'(m_if.out_ovf), 0);
        check("rst_busy", 32'(m_if.busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Consecutive vectors start the cycle after each result handshake.
        for (int i = 0; i < 5; i++) run_main(vecs[i]);

        // Reset part-way through a 5-pair run.
        m_if.start = 1'b1;
        m_if.len   = 8'd5;
        @(negedge clk);
        m_if.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_if.in_valid = 1'b1;
            m_if.in_a     = 8'(i + 10);
            m_if.in_b     = 8'(i + 20);
            @(negedge clk);
        end
        m_if.in_valid = 1'b0;
        check("midrun_busy_before", 32'(m_if.busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", 32'(m_if.busy), 0);
        check("midrun_rst_in_ready", 32'(m_if.in_ready), 0);
        check("midrun_rst_sum", 32'(m_if.out_sum), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("midrun_no_valid", 32'(m_if.out_valid), 0);
        end
        run_main(mk(1, 0, 7, 9, 0, 0, 0, 0, 0, 0, 63, 0));

        // Saturating 16-bit build: sum stays all-ones once it overflows.
        s_if.start = 1'b1;
        s_if.len   = 8'd3;
        @(negedge clk);
        s_if.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_if.in_valid = 1'b1;
            s_if.in_a     = (i == 2) ? 8'd1 : 8'd255;
            s_if.in_b     = (i == 2) ? 8'd1 : 8'd255;
            @(negedge clk);
        end
        s_if.in_valid = 1'b0;
        n = 0;
        while (!s_if.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("sat_valid", 32'(s_if.out_valid), 1);
        check("sat_sum", 32'(s_if.out_sum), 32'h0000_FFFF);
        check("sat_ovf", 32'(s_if.out_ovf), 1);
        s_if.out_ready = 1'b1;
        @(negedge clk);
        s_if.out_ready = 1'b0;
        check("sat_idle", 32'(s_if.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
